// File: rtl/irq_pkg.sv
// Shared interrupt-controller types and constants: FSM states, cause codes,
// exception vector.
package irq_pkg;

  localparam int unsigned N_IRQ   = 4;
  localparam int unsigned CAUSE_W = 2;

  // ENTRY exists only as the combinational phase in which the trap is taken
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Cause codes; equal to the source index, which is also its priority
  localparam logic [CAUSE_W-1:0] IRQ_TIMER   = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] IRQ_UART_RX = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] IRQ_UART_TX = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] IRQ_EXT     = CAUSE_W'(3);

  // Handler entry address selected by the PC mux when begin_interrupt is high
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0004;

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/control/status bundle between the CPU core, peripherals and the
// interrupt controller. master = core/peripheral side, slave = controller.
interface interrupt_controller_if;
  import irq_pkg::*;

  logic [N_IRQ-1:0]   irq_in;
  logic               mask_we;
  logic [N_IRQ-1:0]   mask_wdata;
  logic [N_IRQ-1:0]   pend_clr;
  logic               kernel_mode;
  logic               is_jr_jal;
  logic               int_return;
  logic               begin_interrupt;
  logic [CAUSE_W-1:0] cause;
  logic               in_service;
  logic [N_IRQ-1:0]   mask_q;
  logic [N_IRQ-1:0]   pending_q;

  modport master (
    output irq_in, mask_we, mask_wdata, pend_clr, kernel_mode, is_jr_jal, int_return,
    input  begin_interrupt, cause, in_service, mask_q, pending_q
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, pend_clr, kernel_mode, is_jr_jal, int_return,
    output begin_interrupt, cause, in_service, mask_q, pending_q
  );

endinterface

// File: rtl/irq_edge_sync.sv
// Per-source optional 2-flop synchronizer followed by rising-edge detect.
// Build option: IRQ_SYNC_EN inserts the synchronizer (adds 2 cycles latency).
module irq_edge_sync
  import irq_pkg::*;
#(
  parameter int unsigned N = N_IRQ
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] irq_s;
  logic [N-1:0] irq_d_q;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  // Two-stage synchronizer for asynchronous request pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  // History for edge detection; cleared so a line high out of reset counts as a rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d_q <= '0;
    end else begin
      irq_d_q <= irq_s;
    end
  end

  assign rise_o = irq_s & ~irq_d_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller for the single-cycle MIPS core: latches request edges
// as pending, masks them, picks the lowest-index eligible source and raises a
// same-cycle begin_interrupt when the current instruction can be replaced.
// Tracks one in-service interrupt (no nesting) until `jr $k0` in kernel mode.
// Build option: define IRQ_SYNC_EN to synchronize irq_in before edge detect.
module interrupt_controller
  import irq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  interrupt_controller_if.slave bus
);

  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   eligible_c;
  logic [N_IRQ-1:0]   win_onehot_c;
  logic [CAUSE_W-1:0] winner_c;
  logic               safe_c;
  logic               begin_interrupt_c;

  irq_state_e         state_q, state_d, phase_c;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               in_service_q, in_service_d;

  irq_edge_sync #(
    .N (N_IRQ)
  ) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .irq_i  (bus.irq_in),
    .rise_o (rise)
  );

  assign eligible_c = pending_q & mask_q;
  assign safe_c     = ~bus.kernel_mode & ~bus.is_jr_jal & ~in_service_q;

  // Fixed priority: lowest eligible index wins
  always_comb begin
    winner_c     = '0;
    win_onehot_c = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible_c[i]) begin
        winner_c     = CAUSE_W'(i);
        win_onehot_c = N_IRQ'(1) << i;
      end
    end
  end

  // Next-state, trap entry and pending/mask update
  always_comb begin
    state_d           = state_q;
    phase_c           = state_q;
    begin_interrupt_c = 1'b0;
    cause_d           = cause_q;
    in_service_d      = in_service_q;
    pending_d         = pending_q & ~bus.pend_clr;
    mask_d            = bus.mask_we ? bus.mask_wdata : mask_q;

    // Mealy entry: the trap replaces the instruction in this very cycle
    if (state_q == IDLE && safe_c && (|eligible_c)) begin
      phase_c = ENTRY;
    end

    unique case (phase_c)
      IDLE: begin
        state_d = IDLE;
      end
      ENTRY: begin
        begin_interrupt_c = 1'b1;
        cause_d           = winner_c;
        pending_d         = pending_d & ~win_onehot_c;
        in_service_d      = 1'b1;
        state_d           = SERVICE;
      end
      SERVICE: begin
        if (bus.int_return && bus.kernel_mode) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh rise always latches, winning over any clear of the same bit
    pending_d = pending_d | rise;
  end

  // State and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      mask_q       <= '0;
      cause_q      <= IRQ_TIMER;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      cause_q      <= cause_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.begin_interrupt = begin_interrupt_c;
  assign bus.cause           = cause_q;
  assign bus.in_service      = in_service_q;
  assign bus.mask_q          = mask_q;
  assign bus.pending_q       = pending_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects peripheral interrupt requests (timer, UART RX, UART TX, external), latches them as pending, and applies a mask and a fixed priority.
- Tells the single-cycle MIPS controller when to divert to the handler: `begin_interrupt` feeds the controller's BeginInterrupt input and selects the exception PC.
- Tracks the in-service interrupt until the handler returns with `jr $k0` in kernel mode.

Parameters:
- N_IRQ, 4, number of interrupt sources; index 0 has the highest priority.
- CAUSE_W, 2, width of the cause code; must satisfy 2^CAUSE_W >= N_IRQ.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  N_IRQ  level request lines from peripherals.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  N_IRQ  new mask value; 1 = enabled.
- pend_clr  in  N_IRQ  one-cycle write-1-to-clear for pending bits.
- kernel_mode  in  1  PC[31] of the current instruction.
- is_jr_jal  in  1  IsJrJal from the controller for the current instruction.
- int_return  in  1  current instruction is `jr $k0` executing in kernel mode.
- begin_interrupt  out  1  one-cycle pulse that diverts the current cycle to the handler.
- cause  out  CAUSE_W  index of the interrupt taken; held stable through service.
- in_service  out  1  high from entry until return.
- mask_q  out  N_IRQ  current mask.
- pending_q  out  N_IRQ  current pending bits.

Behaviour:
- Reset values: begin_interrupt=0, cause=0, in_service=0, mask_q=0 (all masked), pending_q=0, FSM=IDLE, edge-detect history = 0.
- Rising-edge detect per source: `rise[i] = irq_s[i] & ~irq_d[i]`.
  - irq_s is the source as seen after the optional synchronizer; irq_d is its value one cycle earlier.
  - A rise sets pending[i] on the next edge, regardless of mask.
  - If rise and pend_clr hit the same bit in the same cycle, set wins.
- Mask update: `mask_we` takes effect on the next edge. A masked pending bit stays pending and is eligible as soon as it is unmasked.
- Eligible set: `pending & mask`.
  - Winner = lowest eligible index.
  - `safe = ~kernel_mode & ~is_jr_jal & ~in_service`.
- FSM states:
  - IDLE: if eligible != 0 and safe, go to ENTRY this cycle (Mealy path). The begin_interrupt pulse lasts one cycle.
  - ENTRY:
    - begin_interrupt=1 combinationally in the same cycle that safe && eligible holds, so the current instruction is replaced by the trap.
    - On the clock edge: cause <= winner; pending[winner] cleared; in_service <= 1; state -> SERVICE.
  - SERVICE:
    - New rises still latch into pending; no further begin_interrupt (no nesting).
    - int_return=1 -> in_service <= 0 and state -> IDLE on the next edge.
    - int_return while kernel_mode=0 is ignored.
  - An eligible interrupt arriving while unsafe waits in IDLE; pending stays set.
- Latency:
  - Rise at irq_in in cycle t -> pending at t+1 (t+3 with IRQ_SYNC_EN).
  - begin_interrupt earliest in the cycle pending is visible, if safe.
- Return and re-entry:
  - The cycle after int_return, a still-eligible request may fire again. No dead cycle is required beyond the state update.
  - A same-cycle int_return and new rise are both honoured.
- cause holds its value after return until the next entry.
- Reset mid-service: all state is cleared immediately (asynchronous); pending interrupts are lost.

Optional Feature:
- IRQ_SYNC_EN
  - Defined: each irq_in bit passes a 2-flop synchronizer (reset to 0) before edge detection. Use this for asynchronous sources, e.g. external pins.
  - Undefined: irq_in is sampled directly. All sources must then be synchronous to clk; latency is 2 cycles shorter.

Decomposition:
- Shared package `irq_pkg`:
  - FSM state enum {IDLE, ENTRY, SERVICE}.
  - Cause codes: IRQ_TIMER=0, IRQ_UART_RX=1, IRQ_UART_TX=2, IRQ_EXT=3.
  - Exception vector constant 32'h80000004, consumed by the PC mux.
- Sub-module `irq_edge_sync`: per-bit optional synchronizer plus rise detect, instantiated N_IRQ wide.
- Priority encoder and FSM stay in the top.

Test Plan:
- Reset, mask=4'b1111, pulse irq_in[0] for 1 cycle with kernel_mode=0 and is_jr_jal=0 -> pending[0] set, then a single begin_interrupt pulse, cause=0, in_service=1, pending[0]=0.
- irq_in[1] and irq_in[3] rise in the same cycle -> entry with cause=1. Pulse int_return -> next cycle begin_interrupt again with cause=3.
- mask=4'b1110, rise irq_in[0] -> pending_q=4'b0001 and no begin_interrupt. Write mask=4'b1111 -> begin_interrupt on the next safe cycle, cause=0.
- Pending[2] set while kernel_mode=1 or is_jr_jal=1 -> no entry. Drop both to 0 -> begin_interrupt in that same cycle, cause=2.
- During SERVICE, rise irq_in[0] -> pending[0]=1 and no begin_interrupt until int_return. int_return with kernel_mode=0 is ignored, and in_service stays 1.
- Assert reset low mid-SERVICE with pending=4'b0100 -> all outputs return to 0 asynchronously. After release, no spurious begin_interrupt from irq_in lines held high.
